// File: rtl/layer_priority_mux_pkg.sv
// Shared constants and helpers for the layer priority mux.
// Pair indexing packs the upper triangle of the layer matrix row by row.
package layer_priority_mux_pkg;

    localparam int MAX_LAYERS = 8;
    localparam int MAX_PAIRS  = MAX_LAYERS * (MAX_LAYERS - 1) / 2;
    localparam int HIT_W      = 3;

    function automatic int rgb_w(input int color_w);
        return 3 * color_w;
    endfunction

    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - i * (i + 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/layer_priority_mux_pair_collision_acc.sv
// Sticky pairwise collision accumulator with per-frame snapshot.
// The frame_start pixel lands in the fresh accumulator, not the snapshot.
module pair_collision_acc
    import layer_priority_mux_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_PAIRS  = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  frame_start,
    input  logic [NUM_LAYERS-1:0] eff,
    output logic [NUM_PAIRS-1:0]  collision_frame
);

    logic [NUM_PAIRS-1:0] pairs;
    logic [NUM_PAIRS-1:0] acc;

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_row
        for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_col
            assign pairs[pair_idx(i, j, NUM_LAYERS)] =
                valid & eff[i] & eff[j];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc             <= '0;
            collision_frame <= '0;
        end else if (frame_start) begin
            collision_frame <= acc;
            acc             <= pairs;
        end else begin
            acc <= acc | pairs;
        end
    end

endmodule

// File: rtl/layer_priority_mux.sv
// Two-stage layer priority mux: lowest effective layer wins the pixel.
// Stage 1 captures effective flags and colours, stage 2 the selection.
module layer_priority_mux
    import layer_priority_mux_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4,
    parameter logic [3*COLOR_W-1:0] TRANSP_RGB = 12'hF0F,
    localparam int NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2,
    localparam int RGB_W     = rgb_w(COLOR_W)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pxl_valid,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS-1:0]       draw_in,
    input  logic [NUM_LAYERS*RGB_W-1:0] rgb_in,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]            rgb_bg,
    output logic [COLOR_W-1:0]          Red_level,
    output logic [COLOR_W-1:0]          Green_level,
    output logic [COLOR_W-1:0]          Blue_level,
    output logic                        draw_any,
    output logic [HIT_W-1:0]            hit_layer,
    output logic                        collision_now,
    output logic [NUM_PAIRS-1:0]        collision_frame
);

    logic [NUM_LAYERS-1:0]       eff_in;
    logic                        s1_valid;
    logic                        s1_fs;
    logic [NUM_LAYERS-1:0]       s1_eff;
    logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
    logic [RGB_W-1:0]            s1_bg;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_eff
        assign eff_in[g] = draw_in[g] & layer_en[g] &
            (rgb_in[g*RGB_W +: RGB_W] != TRANSP_RGB);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_fs    <= 1'b0;
            s1_eff   <= '0;
            s1_rgb   <= '0;
            s1_bg    <= '0;
        end else begin
            s1_valid <= pxl_valid;
            s1_fs    <= frame_start;
            s1_eff   <= eff_in & {NUM_LAYERS{pxl_valid}};
            s1_rgb   <= rgb_in;
            s1_bg    <= rgb_bg;
        end
    end

    // Isolate the lowest set bit, then OR-reduce the one-hot mux.
    logic [NUM_LAYERS-1:0] win_oh;
    logic [RGB_W-1:0]      or_rgb [NUM_LAYERS+1];
    logic [HIT_W-1:0]      or_hit [NUM_LAYERS+1];

    assign win_oh    = s1_eff & (~s1_eff + 1'b1);
    assign or_rgb[0] = '0;
    assign or_hit[0] = '0;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_sel
        assign or_rgb[g+1] = or_rgb[g] |
            ({RGB_W{win_oh[g]}} & s1_rgb[g*RGB_W +: RGB_W]);
        assign or_hit[g+1] = or_hit[g] |
            ({HIT_W{win_oh[g]}} & HIT_W'(g));
    end

    logic [RGB_W-1:0] sel_rgb;
    logic [HIT_W-1:0] sel_hit;
    logic             sel_any;
    logic             sel_coll;

    always_comb begin
        sel_rgb  = '0;
        sel_hit  = '0;
        sel_any  = 1'b0;
        sel_coll = 1'b0;
        if (s1_valid) begin
            sel_any  = |s1_eff;
            sel_coll = |(s1_eff & (s1_eff - 1'b1));
            sel_hit  = or_hit[NUM_LAYERS];
            sel_rgb  = sel_any ? or_rgb[NUM_LAYERS] : s1_bg;
        end
    end

    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q         <= '0;
            hit_layer     <= '0;
            draw_any      <= 1'b0;
            collision_now <= 1'b0;
        end else begin
            rgb_q         <= sel_rgb;
            hit_layer     <= sel_hit;
            draw_any      <= sel_any;
            collision_now <= sel_coll;
        end
    end

    assign Red_level   = rgb_q[RGB_W-1 -: COLOR_W];
    assign Green_level = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign Blue_level  = rgb_q[COLOR_W-1:0];

    pair_collision_acc #(
        .NUM_LAYERS (NUM_LAYERS),
        .NUM_PAIRS  (NUM_PAIRS)
    ) u_acc (
        .clk             (clk),
        .reset           (reset),
        .valid           (s1_valid),
        .frame_start     (s1_fs),
        .eff             (s1_eff),
        .collision_frame (collision_frame)
    );

endmodule

// File: tb/tb_layer_priority_mux.sv
// Scoreboard bench for layer_priority_mux with NUM_LAYERS=4.
// Expected results are queued at drive time and checked 2 cycles later.
module tb_layer_priority_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pxl_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  draw_in = '0;
    logic [47:0] rgb_in = '0;
    logic [3:0]  layer_en = '0;
    logic [11:0] rgb_bg = '0;
    logic [3:0]  Red_level, Green_level, Blue_level;
    logic        draw_any;
    logic [2:0]  hit_layer;
    logic        collision_now;
    logic [5:0]  collision_frame;

    typedef struct {
        logic [11:0] rgb;
        logic        da;
        logic [2:0]  hit;
        logic        cn;
        logic [5:0]  cf;
    } exp_t;

    exp_t       q[$];
    logic [5:0] m_acc = '0;
    logic [5:0] m_cf  = '0;
    int         n_tests = 0;
    int         n_fail  = 0;

    layer_priority_mux #(
        .NUM_LAYERS (4),
        .COLOR_W    (4),
        .TRANSP_RGB (12'hF0F)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pxl_valid       (pxl_valid),
        .frame_start     (frame_start),
        .draw_in         (draw_in),
        .rgb_in          (rgb_in),
        .layer_en        (layer_en),
        .rgb_bg          (rgb_bg),
        .Red_level       (Red_level),
        .Green_level     (Green_level),
        .Blue_level      (Blue_level),
        .draw_any        (draw_any),
        .hit_layer       (hit_layer),
        .collision_now   (collision_now),
        .collision_frame (collision_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".rgb"}, {20'd0, Red_level, Green_level, Blue_level},
              {20'd0, e.rgb});
        check({tag, ".any"}, {31'd0, draw_any}, {31'd0, e.da});
        check({tag, ".hit"}, {29'd0, hit_layer}, {29'd0, e.hit});
        check({tag, ".coll"}, {31'd0, collision_now}, {31'd0, e.cn});
        check({tag, ".cf"}, {26'd0, collision_frame}, {26'd0, e.cf});
    endtask

    task automatic step(input logic v, input logic fs,
                        input logic [3:0] dr, input logic [3:0] en,
                        input logic [11:0] r0, input logic [11:0] r1,
                        input logic [11:0] r2, input logic [11:0] r3,
                        input logic [11:0] bg);
        logic [11:0] r[4];
        logic [3:0]  eff;
        logic [5:0]  pairs;
        exp_t        e;
        int          k;
        int          cnt;
        @(negedge clk);
        if (q.size() >= 2) check_out("pix", q.pop_front());
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        pxl_valid = v; frame_start = fs; draw_in = dr; layer_en = en;
        rgb_in = {r3, r2, r1, r0}; rgb_bg = bg;
        eff = '0;
        for (int i = 0; i < 4; i++)
            eff[i] = v & dr[i] & en[i] & (r[i] != 12'hF0F);
        pairs = '0;
        k = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++) begin
                if (eff[i] && eff[j]) pairs = pairs | (6'd1 << k);
                k++;
            end
        if (fs) begin
            m_cf  = m_acc;
            m_acc = pairs;
        end else begin
            m_acc = m_acc | pairs;
        end
        e.rgb = '0; e.da = 1'b0; e.hit = '0; e.cn = 1'b0; e.cf = m_cf;
        if (v) begin
            e.rgb = bg;
            cnt = 0;
            for (int i = 3; i >= 0; i--)
                if (eff[i]) begin
                    e.rgb = r[i];
                    e.hit = 3'(i);
                    e.da  = 1'b1;
                    cnt++;
                end
            e.cn = (cnt >= 2);
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 4'h0, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    endtask

    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        reset = 1'b1;
        pxl_valid = 1'b0; frame_start = 1'b0; draw_in = '0;
        q.delete();
        m_acc = '0; m_cf = '0;
        z.rgb = '0; z.da = 1'b0; z.hit = '0; z.cn = 1'b0; z.cf = '0;
        @(negedge clk);
        check_out("rst", z);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [11:0] pal[6];

    initial begin
        pal[0] = 12'hF0F; pal[1] = 12'h0F0; pal[2] = 12'hF00;
        pal[3] = 12'h00F; pal[4] = 12'h123; pal[5] = 12'hABC;
        do_reset();
        // two overlapping layers: layer 1 wins
        step(1, 0, 4'b0110, 4'hF, 12'h000, 12'h0F0, 12'hF00, 12'h000, 12'h000);
        // transparent layer 0 falls through to layer 1
        step(1, 0, 4'b0011, 4'hF, 12'hF0F, 12'h00F, 12'h000, 12'h000, 12'h000);
        // background, then blanked pixel
        step(1, 0, 4'b0000, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF);
        step(0, 0, 4'b1111, 4'hF, 12'h111, 12'h222, 12'h333, 12'h444, 12'hFFF);
        // new frame, then layers 0/3 overlap, then snapshot, then clean frame
        step(1, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        step(1, 0, 4'b1001, 4'hF, 12'h00F, 12'h0, 12'h0, 12'hF00, 12'h000);
        idle(2);
        step(1, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        idle(3);
        step(1, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        idle(3);
        // overlap on the frame_start pixel goes to the next snapshot
        step(1, 1, 4'b0110, 4'hF, 12'h0, 12'h0F0, 12'hF00, 12'h0, 12'h000);
        idle(2);
        step(1, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        idle(2);
        // blank frame_start still snapshots and clears
        step(0, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        idle(2);
        // reset mid-frame discards a 0/1 collision
        step(1, 0, 4'b0011, 4'hF, 12'hF00, 12'h0F0, 12'h0, 12'h0, 12'h000);
        do_reset();
        step(1, 1, 4'b0000, 4'hF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h000);
        step(1, 0, 4'b0011, 4'b1110, 12'hF00, 12'h0F0, 12'h0, 12'h0, 12'h000);
        idle(3);
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 pal[$urandom_range(0, 5)], pal[$urandom_range(0, 5)],
                 pal[$urandom_range(0, 5)], pal[$urandom_range(0, 5)],
                 12'($urandom));
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
